cordic_sincos_responder: RTL and testbench



---
 rtl/cordic_atan_radian_table_pkg.sv | 24 ++
 rtl/cordic_axi4s_types_pkg.sv | 45 ++++
 rtl/cordic_quadrant_fold.sv | 35 +++
 rtl/cordic_sincos_responder.sv | 171 +++++++++++++++++
 tb/tb_cordic_sincos_responder.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cordic_atan_radian_table_pkg.sv
// atan(2^-i) in radians, stored in Q30 and truncated to the requested Q format.
package cordic_atan_radian_table_pkg;

    localparam logic signed [31:0] ATAN_Q30 [30] = '{
        32'sh3243F6A8, 32'sh1DAC6705, 32'sh0FADBAFC, 32'sh07F56EA6,
        32'sh03FEAB76, 32'sh01FFD55B, 32'sh00FFFAAA, 32'sh007FFF55,
        32'sh003FFFEA, 32'sh001FFFFD, 32'sh000FFFFF, 32'sh0007FFFF,
        32'sh0003FFFF, 32'sh0001FFFF, 32'sh0000FFFF, 32'sh00007FFF,
        32'sh00003FFF, 32'sh00001FFF, 32'sh00000FFF, 32'sh000007FF,
        32'sh000003FF, 32'sh000001FF, 32'sh000000FF, 32'sh0000007F,
        32'sh0000003F, 32'sh0000001F, 32'sh0000000F, 32'sh00000007,
        32'sh00000003, 32'sh00000001
    };

    function automatic logic signed [63:0] cordic_atan_q(input int idx, input int frac_bits);
        logic signed [63:0] v;
        v = 64'(ATAN_Q30[idx]);
        if (frac_bits <= 30) begin
            return v >>> (30 - frac_bits);
        end
        return v <<< (frac_bits - 30);
    endfunction

endpackage

// File: rtl/cordic_axi4s_types_pkg.sv
// Shared CORDIC AXI4-S types: request mode enum, CORDIC gain and pi constants.
// Pi-derived constants are generated for any Q format from one high-precision pi.
package cordic_axi4s_types_pkg;

    typedef enum logic {
        CORDIC_SINE_COSINE_E = 1'b0,
        CORDIC_UNSUPPORTED_E = 1'b1
    } cordic_mode_e;

    // pi in Q60, and 1/K (0.607252935) in Q30
    localparam logic signed [63:0] PI_Q60        = 64'sh3243F6A8885A308D;
    localparam logic signed [63:0] GAIN_INV_Q30  = 64'sd652032874;

    // Returns round(halves * pi/2) in Q(frac_bits); frac_bits <= 60
    function automatic logic signed [63:0] cordic_pi_q(input int frac_bits, input int halves);
        logic signed [127:0] acc;
        int shift;
        shift = 61 - frac_bits;
        acc   = 128'(PI_Q60) * 128'(halves);
        acc   = (acc + (128'sd1 <<< (shift - 1))) >>> shift;
        return acc[63:0];
    endfunction

    function automatic logic signed [63:0] PI(input int frac_bits);
        return cordic_pi_q(frac_bits, 2);
    endfunction

    function automatic logic signed [63:0] PI_HALF(input int frac_bits);
        return cordic_pi_q(frac_bits, 1);
    endfunction

    function automatic logic signed [63:0] PI2(input int frac_bits);
        return cordic_pi_q(frac_bits, 4);
    endfunction

    function automatic logic signed [63:0] CORDIC_GAIN_INV(input int frac_bits);
        logic signed [63:0] v;
        v = GAIN_INV_Q30;
        if (frac_bits <= 30) begin
            return v >>> (30 - frac_bits);
        end
        return v <<< (frac_bits - 30);
    endfunction

endpackage

// File: rtl/cordic_quadrant_fold.sv
// Maps an angle in [0, 2*pi) onto z in [-pi/2, pi/2] plus a cosine sign flag,
// keeping the CORDIC inside its convergence range.
module cordic_quadrant_fold
    import cordic_axi4s_types_pkg::*;
#(
    parameter int W = 32
) (
    input  logic signed [W-1:0] theta,
    output logic signed [W+1:0] z,
    output logic                negate_cos
);

    localparam int XW = W + 2;
    localparam logic signed [XW-1:0] PI_X      = XW'(PI(W - 4));
    localparam logic signed [XW-1:0] PI_HALF_X = XW'(PI_HALF(W - 4));
    localparam logic signed [XW-1:0] PI2_X     = XW'(PI2(W - 4));

    logic signed [XW-1:0] theta_x;
    logic signed [XW-1:0] wrapped;

    always_comb begin
        theta_x    = {{2{theta[W-1]}}, theta};
        wrapped    = (theta_x >= PI_X) ? theta_x - PI2_X : theta_x;
        z          = wrapped;
        negate_cos = 1'b0;
        if (wrapped > PI_HALF_X) begin
            z          = PI_X - wrapped;
            negate_cos = 1'b1;
        end else if (wrapped < -PI_HALF_X) begin
            z          = -PI_X - wrapped;
            negate_cos = 1'b1;
        end
    end

endmodule

// File: rtl/cordic_sincos_responder.sv
// Iterative CORDIC sine/cosine responder on AXI4-S, one micro-rotation per clock.
// Optional macro CORDIC_UNITY_SATURATE_EN clamps each result half to [-1, +1].
module cordic_sincos_responder
    import cordic_axi4s_types_pkg::*;
    import cordic_atan_radian_table_pkg::*;
#(
    parameter int AXI_DATA_WIDTH_P = 32,
    parameter int AXI_ID_WIDTH_P   = 4,
    parameter int NR_OF_STAGES_P   = 24
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ing_tvalid,
    output logic                          ing_tready,
    input  logic [AXI_DATA_WIDTH_P-1:0]   ing_tdata,
    input  logic                          ing_tlast,
    input  logic [AXI_ID_WIDTH_P-1:0]     ing_tid,
    input  logic                          ing_tuser,
    output logic                          egr_tvalid,
    input  logic                          egr_tready,
    output logic [2*AXI_DATA_WIDTH_P-1:0] egr_tdata,
    output logic                          egr_tlast,
    output logic [AXI_ID_WIDTH_P-1:0]     egr_tid
);

    localparam int W    = AXI_DATA_WIDTH_P;
    localparam int FRAC = W - 4;
    localparam int XW   = W + 2;
    localparam int CW   = $clog2(NR_OF_STAGES_P + 1);
    localparam logic signed [XW-1:0] GAIN_INV_X = XW'(CORDIC_GAIN_INV(FRAC));

    typedef enum logic [1:0] {
        IDLE_S,
        PREP_S,
        ROTATE_S,
        OUTPUT_S
    } state_e;

    state_e                   state;
    logic signed [W-1:0]      theta_q;
    logic [AXI_ID_WIDTH_P-1:0] tid_q;
    cordic_mode_e             mode_q;
    logic                     negate_cos_q;
    logic signed [XW-1:0]     x_q, y_q, z_q;
    logic [CW-1:0]            iter_q;

    logic signed [XW-1:0]     fold_z;
    logic                     fold_negate;
    logic signed [XW-1:0]     x_shift, y_shift, atan_i;
    logic signed [XW-1:0]     x_next, y_next, z_next;
    logic signed [W-1:0]      sin_w, cos_w;
    logic [2*W-1:0]           resp_data;

    logic unused_tlast;
    assign unused_tlast = ing_tlast;

    cordic_quadrant_fold #(.W(W)) u_fold (
        .theta      (theta_q),
        .z          (fold_z),
        .negate_cos (fold_negate)
    );

`ifdef CORDIC_UNITY_SATURATE_EN
    localparam logic signed [XW-1:0] ONE_X = XW'(64'sd1 <<< FRAC);
    logic signed [XW-1:0] cos_x;

    function automatic logic signed [W-1:0] clamp_unity(input logic signed [XW-1:0] v);
        logic signed [XW-1:0] c;
        c = v;
        if (v > ONE_X) begin
            c = ONE_X;
        end else if (v < -ONE_X) begin
            c = -ONE_X;
        end
        return c[W-1:0];
    endfunction
`endif

    // One micro-rotation: d = +1 for z >= 0, -1 otherwise
    always_comb begin
        x_shift = x_q >>> iter_q;
        y_shift = y_q >>> iter_q;
        atan_i  = XW'(cordic_atan_q(int'(iter_q), FRAC));
        if (z_q[XW-1]) begin
            x_next = x_q + y_shift;
            y_next = y_q - x_shift;
            z_next = z_q + atan_i;
        end else begin
            x_next = x_q - y_shift;
            y_next = y_q + x_shift;
            z_next = z_q - atan_i;
        end
    end

    always_comb begin
`ifdef CORDIC_UNITY_SATURATE_EN
        cos_x = negate_cos_q ? -x_q : x_q;
        sin_w = clamp_unity(y_q);
        cos_w = clamp_unity(cos_x);
`else
        sin_w = y_q[W-1:0];
        cos_w = negate_cos_q ? -x_q[W-1:0] : x_q[W-1:0];
`endif
        resp_data = (mode_q == CORDIC_SINE_COSINE_E) ? {sin_w, cos_w} : '0;
    end

    // OUTPUT spends its first cycle registering the result, then waits for egr_tready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE_S;
            ing_tready   <= 1'b1;
            egr_tvalid   <= 1'b0;
            egr_tdata    <= '0;
            egr_tlast    <= 1'b0;
            egr_tid      <= '0;
            theta_q      <= '0;
            tid_q        <= '0;
            mode_q       <= CORDIC_SINE_COSINE_E;
            negate_cos_q <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            z_q          <= '0;
            iter_q       <= '0;
        end else begin
            case (state)
                IDLE_S: begin
                    if (ing_tvalid && ing_tready) begin
                        theta_q    <= ing_tdata;
                        tid_q      <= ing_tid;
                        mode_q     <= cordic_mode_e'(ing_tuser);
                        ing_tready <= 1'b0;
                        state      <= PREP_S;
                    end
                end
                PREP_S: begin
                    x_q          <= GAIN_INV_X;
                    y_q          <= '0;
                    z_q          <= fold_z;
                    negate_cos_q <= fold_negate;
                    iter_q       <= '0;
                    state        <= ROTATE_S;
                end
                ROTATE_S: begin
                    x_q <= x_next;
                    y_q <= y_next;
                    z_q <= z_next;
                    if (iter_q == CW'(NR_OF_STAGES_P - 1)) begin
                        state <= OUTPUT_S;
                    end else begin
                        iter_q <= iter_q + 1'b1;
                    end
                end
                OUTPUT_S: begin
                    if (!egr_tvalid) begin
                        egr_tvalid <= 1'b1;
                        egr_tdata  <= resp_data;
                        egr_tlast  <= 1'b1;
                        egr_tid    <= tid_q;
                    end else if (egr_tready) begin
                        egr_tvalid <= 1'b0;
                        egr_tlast  <= 1'b0;
                        ing_tready <= 1'b1;
                        state      <= IDLE_S;
                    end
                end
                default: state <= IDLE_S;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_sincos_responder.sv
// Self-checking bench for cordic_sincos_responder: real-valued sin/cos model,
// per-cycle compare process, and directed vectors with hand-computed results.
module tb_cordic_sincos_responder;

    localparam int    N       = 24;
    localparam int    LAT     = N + 2;
    localparam longint ONE    = 268435456;
    localparam longint TOL    = 64;

    logic        clk;
    logic        rst_n;
    logic        ing_tvalid;
    logic        ing_tready;
    logic [31:0] ing_tdata;
    logic        ing_tlast;
    logic [3:0]  ing_tid;
    logic        ing_tuser;
    logic        egr_tvalid;
    logic        egr_tready;
    logic [63:0] egr_tdata;
    logic        egr_tlast;
    logic [3:0]  egr_tid;

    cordic_sincos_responder #(
        .AXI_DATA_WIDTH_P (32),
        .AXI_ID_WIDTH_P   (4),
        .NR_OF_STAGES_P   (N)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ing_tvalid (ing_tvalid),
        .ing_tready (ing_tready),
        .ing_tdata  (ing_tdata),
        .ing_tlast  (ing_tlast),
        .ing_tid    (ing_tid),
        .ing_tuser  (ing_tuser),
        .egr_tvalid (egr_tvalid),
        .egr_tready (egr_tready),
        .egr_tdata  (egr_tdata),
        .egr_tlast  (egr_tlast),
        .egr_tid    (egr_tid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        longint     accept_edge;
        logic [3:0] tid;
        logic       mode;
        logic       check_data;
        longint     theta;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    longint      edge_cnt = 0;
    logic        prev_valid = 1'b0;
    logic [63:0] prev_data = '0;
    logic [3:0]  prev_tid = '0;
    logic        hs_pending = 1'b0;

    task automatic check_output(input string name, input longint actual,
                                input longint expected, input longint tol);
        checks++;
        if ((actual - expected > tol) || (expected - actual > tol)) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d tol=%0d", name, actual, expected, tol);
        end
    endtask

    function automatic longint model_sin(input longint theta);
        return longint'($sin($itor(theta) / 268435456.0) * 268435456.0);
    endfunction

    function automatic longint model_cos(input longint theta);
        return longint'($cos($itor(theta) / 268435456.0) * 268435456.0);
    endfunction

    function automatic longint hi_half(input logic [63:0] d);
        return longint'($signed(d[63:32]));
    endfunction

    function automatic longint lo_half(input logic [63:0] d);
        return longint'($signed(d[31:0]));
    endfunction

    always @(posedge clk) edge_cnt = edge_cnt + 1;

    // Compare process: sampled on the falling edge, inputs change 3 units after rising edge
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            hs_pending = 1'b0;
            check_output("reset_ing_tready", longint'(ing_tready), 1, 0);
            check_output("reset_egr_tvalid", longint'(egr_tvalid), 0, 0);
            check_output("reset_egr_tdata_nonzero", longint'(egr_tdata != 0), 0, 0);
            check_output("reset_egr_tlast", longint'(egr_tlast), 0, 0);
            check_output("reset_egr_tid", longint'(egr_tid), 0, 0);
        end else begin
            if (hs_pending) begin
                check_output("post_hs_tvalid", longint'(egr_tvalid), 0, 0);
                check_output("post_hs_ing_tready", longint'(ing_tready), 1, 0);
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                hs_pending = 1'b0;
            end
            if (egr_tvalid) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_response", 1, 0, 0);
                end else if (!prev_valid) begin
                    check_output("latency", edge_cnt - exp_q[0].accept_edge, LAT, 0);
                    check_output("tid_echo", longint'(egr_tid), longint'(exp_q[0].tid), 0);
                    check_output("tlast", longint'(egr_tlast), 1, 0);
                    if (exp_q[0].mode) begin
                        check_output("unsupported_zero_sin", hi_half(egr_tdata), 0, 0);
                        check_output("unsupported_zero_cos", lo_half(egr_tdata), 0, 0);
                    end else if (exp_q[0].check_data) begin
                        check_output("model_sin", hi_half(egr_tdata), model_sin(exp_q[0].theta), TOL);
                        check_output("model_cos", lo_half(egr_tdata), model_cos(exp_q[0].theta), TOL);
                    end
`ifdef CORDIC_UNITY_SATURATE_EN
                    check_output("sat_sin_range", longint'(hi_half(egr_tdata) > ONE || hi_half(egr_tdata) < -ONE), 0, 0);
                    check_output("sat_cos_range", longint'(lo_half(egr_tdata) > ONE || lo_half(egr_tdata) < -ONE), 0, 0);
`endif
                end else begin
                    check_output("hold_tdata_stable", longint'(egr_tdata != prev_data), 0, 0);
                    check_output("hold_tid_stable", longint'(egr_tid), longint'(prev_tid), 0);
                    check_output("hold_ing_tready", longint'(ing_tready), 0, 0);
                end
                if (egr_tready) hs_pending = 1'b1;
            end else if (exp_q.size() > 0 && edge_cnt > exp_q[0].accept_edge + LAT) begin
                check_output("response_timeout", 0, 1, 0);
                void'(exp_q.pop_front());
            end
            prev_valid = egr_tvalid;
            prev_data  = egr_tdata;
            prev_tid   = egr_tid;
            if (ing_tvalid && ing_tready) begin
                exp_q.push_back('{accept_edge: edge_cnt + 1, tid: ing_tid, mode: ing_tuser,
                                  check_data: (ing_tdata < 32'd1686629713), theta: longint'(ing_tdata)});
            end
        end
        if (!rst_n) prev_valid = 1'b0;
    end

    task automatic apply_stimulus(input logic [31:0] theta, input logic [3:0] tid, input logic mode);
        int n;
        n = 0;
        while (!ing_tready && n < 200) begin
            @(posedge clk); #3;
            n++;
        end
        if (!ing_tready) check_output("ing_tready_timeout", 0, 1, 0);
        ing_tvalid = 1'b1;
        ing_tdata  = theta;
        ing_tid    = tid;
        ing_tuser  = mode;
        ing_tlast  = 1'b1;
        @(posedge clk); #3;
        ing_tvalid = 1'b0;
        ing_tdata  = $urandom;
        ing_tid    = 4'($urandom_range(0, 15));
    endtask

    task automatic wait_response(input int hold, input logic poke, output logic [63:0] data,
                                 output logic [3:0] tid);
        int n;
        n = 0;
        data = '0;
        tid  = '0;
        while (!egr_tvalid && n < 200) begin
            @(posedge clk); #3;
            n++;
        end
        if (!egr_tvalid) begin
            check_output("egr_tvalid_timeout", 0, 1, 0);
        end else begin
            data = egr_tdata;
            tid  = egr_tid;
            if (poke) begin
                ing_tvalid = 1'b1;
                ing_tdata  = 32'd100000000;
                ing_tuser  = 1'b0;
            end
            repeat (hold) begin
                @(posedge clk); #3;
            end
            ing_tvalid = 1'b0;
            egr_tready = 1'b1;
            @(posedge clk); #3;
            egr_tready = 1'b0;
        end
    endtask

    logic [63:0] d;
    logic [3:0]  t;
    longint      sweep [6] = '{140552476, 280000000, 632486143, 1054143571, 1475800999, 1600000000};

    initial begin
        rst_n      = 1'b0;
        ing_tvalid = 1'b0;
        ing_tdata  = '0;
        ing_tlast  = 1'b0;
        ing_tid    = '0;
        ing_tuser  = 1'b0;
        egr_tready = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #3;

        $display("[TB] pinning the reference model");
        check_output("pin_model_cos0", model_cos(0), 268435456, 0);
        check_output("pin_model_sin_pi2", model_sin(421657428), 268435456, 0);
        check_output("pin_model_cos_pi", model_cos(843314857), -268435456, 0);

        $display("[TB] theta=0, tid=5");
        apply_stimulus(32'd0, 4'd5, 1'b0);
        wait_response(0, 1'b0, d, t);
        check_output("t1_sin", hi_half(d), 0, TOL);
        check_output("t1_cos", lo_half(d), 268435456, TOL);
        check_output("t1_tid", longint'(t), 5, 0);
`ifdef CORDIC_UNITY_SATURATE_EN
        check_output("t1_sat_cos_le_one", longint'(lo_half(d) > ONE), 0, 0);
`endif

        $display("[TB] theta=pi/2");
        apply_stimulus(32'd421657428, 4'd3, 1'b0);
        wait_response(0, 1'b0, d, t);
        check_output("t2_sin", hi_half(d), 268435456, TOL);
        check_output("t2_cos", lo_half(d), 0, TOL);

        $display("[TB] theta=pi and 3*pi/2");
        apply_stimulus(32'd843314857, 4'd7, 1'b0);
        wait_response(0, 1'b0, d, t);
        check_output("t3_pi_sin", hi_half(d), 0, TOL);
        check_output("t3_pi_cos", lo_half(d), -268435456, TOL);
        apply_stimulus(32'd1264972285, 4'd9, 1'b0);
        wait_response(0, 1'b0, d, t);
        check_output("t3_3pi2_sin", hi_half(d), -268435456, TOL);
        check_output("t3_3pi2_cos", lo_half(d), 0, TOL);

        $display("[TB] angle sweep against model");
        foreach (sweep[i]) begin
            apply_stimulus(32'(sweep[i]), 4'(i + 10), 1'b0);
            wait_response(0, 1'b0, d, t);
        end

        $display("[TB] backpressure, 10 cycles");
        apply_stimulus(32'd210828714, 4'd2, 1'b0);
        wait_response(10, 1'b1, d, t);
        check_output("t4_sin", hi_half(d), 189812531, TOL);
        check_output("t4_cos", lo_half(d), 189812531, TOL);
        check_output("t4_ready_after", longint'(ing_tready), 1, 0);

        $display("[TB] reset during rotation");
        apply_stimulus(32'd300000000, 4'd4, 1'b0);
        repeat (8) @(posedge clk);
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        check_output("t5_ready_after_reset", longint'(ing_tready), 1, 0);
        repeat (LAT + 6) @(posedge clk);
        #3;
        check_output("t5_no_response", longint'(egr_tvalid), 0, 0);
        apply_stimulus(32'd421657428, 4'd6, 1'b0);
        wait_response(0, 1'b0, d, t);
        check_output("t5_after_sin", hi_half(d), 268435456, TOL);
        check_output("t5_after_tid", longint'(t), 6, 0);

        $display("[TB] unsupported mode");
        apply_stimulus(32'd421657428, 4'd8, 1'b1);
        wait_response(0, 1'b0, d, t);
        check_output("t6_unsupported_data_nonzero", longint'(d != 0), 0, 0);
        check_output("t6_unsupported_tid", longint'(t), 8, 0);

        $display("[TB] out-of-range angle still handshakes");
        apply_stimulus(32'h7FFF_FFF0, 4'd1, 1'b0);
        wait_response(2, 1'b0, d, t);
        check_output("t7_oor_tid", longint'(t), 1, 0);

        repeat (4) @(posedge clk);
        #3;
        check_output("end_queue_empty", longint'(exp_q.size()), 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
